// File: rtl/imem_loader_if.sv
// Host byte stream plus instruction-memory address/write bus used by imem_loader.
// master = loader side, slave = host/memory side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport master (input in_valid, in_data, output in_ready, mem_addr, mem_we, mem_wdata);
  modport slave  (output in_valid, in_data, input in_ready, mem_addr, mem_we, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Holds the core, assembles host bytes into little-endian words written from word 0, then releases it.
// Define IMEM_LOAD_CHECKSUM_EN to require a 32-bit sum trailer before the core is released.
module imem_loader #(
  parameter int DEPTH     = 1024,
  parameter int AW        = 10,
  parameter bit BOOT_HOLD = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_start,
  input  logic [AW:0]   load_len,
  input  logic [31:0]   cpu_addr,
  imem_loader_if.master bus,
  output logic          cpu_hold,
  output logic          load_busy,
  output logic          load_done,
  output logic          load_err,
  output logic [AW:0]   words_written
);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
`ifdef IMEM_LOAD_CHECKSUM_EN
    S_CHECK   = 3'd3,
`endif
    S_FINISH  = 3'd4
  } state_t;

  // Where the load goes once the last word has been written.
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t      r_state, w_next;
  logic [AW:0] r_len, r_words;
  logic [1:0]  r_bcnt;
  logic [23:0] r_word;
  logic        r_hold, r_busy, r_done, r_we;
  logic [31:0] r_wdata;
  logic        w_in_ready, w_accept, w_last_byte;
  logic [31:0] w_word;
  logic [AW:0] w_len_sat;

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_err;
  assign w_in_ready = (r_state == S_COLLECT) || (r_state == S_CHECK);
`else
  assign w_in_ready = (r_state == S_COLLECT);
`endif

  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_last_byte = w_accept & (r_bcnt == 2'd3);
  // r_word holds the three earlier bytes of the word; the incoming byte lands on top.
  assign w_word      = {bus.in_data, r_word};
  assign w_len_sat   = (load_len > DEPTH_W) ? DEPTH_W : load_len;

  assign bus.in_ready  = w_in_ready;
  assign bus.mem_addr  = (r_state == S_IDLE) ? cpu_addr
                                             : {{(30-AW){1'b0}}, r_words[AW-1:0], 2'b00};
  assign bus.mem_we    = r_we;
  assign bus.mem_wdata = r_wdata;
  assign cpu_hold      = r_hold;
  assign load_busy     = r_busy;
  assign load_done     = r_done;
  assign words_written = r_words;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (load_start) w_next = (w_len_sat == '0) ? S_TAIL : S_COLLECT;
      S_COLLECT: if (w_last_byte) w_next = S_WRITE;
      S_WRITE:   w_next = (r_words + ONE == r_len) ? S_TAIL : S_COLLECT;
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK:   if (w_last_byte) w_next = (w_word == r_sum) ? S_FINISH : S_IDLE;
`endif
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_words <= '0;
      r_bcnt  <= '0;
      r_word  <= '0;
      r_hold  <= BOOT_HOLD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != S_IDLE);
      r_done  <= (w_next == S_FINISH);
      r_we    <= (w_next == S_WRITE);
      if (w_accept) begin
        r_word <= w_word[31:8];
        r_bcnt <= r_bcnt + 2'd1;
      end
      case (r_state)
        S_IDLE: if (load_start) begin
          r_len   <= w_len_sat;
          r_words <= '0;
          r_bcnt  <= '0;
          r_hold  <= 1'b1;
        end
        S_COLLECT: if (w_last_byte) r_wdata <= w_word;
        S_WRITE:   r_words <= r_words + ONE;
        S_FINISH:  r_hold <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef IMEM_LOAD_CHECKSUM_EN
  // A failed trailer leaves cpu_hold set so the core never runs a corrupt image.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_IDLE && load_start) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_sum <= r_sum + r_wdata;
    end else if (r_state == S_CHECK && w_last_byte && w_word != r_sum) begin
      r_err <= 1'b1;
    end
  end
  assign load_err = r_err;
`else
  assign load_err = 1'b0;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader; expected writes and done latencies are queued at stimulus time.
module tb_imem_loader;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
`ifdef IMEM_LOAD_CHECKSUM_EN
  localparam bit CKS = 1'b1;
`else
  localparam bit CKS = 1'b0;
`endif

  typedef logic [31:0] wq_t[$];
  typedef logic [7:0]  bq_t[$];
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_start = 1'b0;
  logic [AW:0] load_len = '0;
  logic [31:0] cpu_addr = 32'h0000_0010;
  logic        cpu_hold, load_busy, load_done, load_err;
  logic [AW:0] words_written;

  imem_loader_if bus();

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .BOOT_HOLD(1'b1)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_len(load_len),
    .cpu_addr(cpu_addr), .bus(bus), .cpu_hold(cpu_hold), .load_busy(load_busy),
    .load_done(load_done), .load_err(load_err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_tests = 0, n_fail = 0, done_cnt = 0, start_cyc = 0;
  wr_t exp_wr[$];
  int  exp_done[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT writes memory or reports completion.
  initial begin : monitor
    wr_t e;
    int  lat;
    forever begin
      @(posedge clk); #1;
      if (!reset && bus.mem_we) begin
        if (exp_wr.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL wr_unexpected: addr %08h data %08h, no write expected", bus.mem_addr, bus.mem_wdata);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", bus.mem_addr, e.addr);
          chk("wr_data", bus.mem_wdata, e.data);
        end
      end
      if (!reset && load_done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: load_done at cycle %0d, none expected", cyc);
        end else begin
          lat = exp_done.pop_front();
          if (lat >= 0) chk("done_latency", cyc - start_cyc, lat);
        end
      end
    end
  end

  // mode 0: back-to-back, 1: valid every other cycle, 2: random gaps. poke pulses load_start mid-load.
  task automatic send_bytes(input bq_t b, input int mode, input bit poke);
    int i = 0;
    int guard = 0;
    bit gap;
    bit alt = 1'b0;
    while (i < b.size()) begin
      @(negedge clk);
      load_start = 1'b0;
      if (mode == 1) begin gap = alt; alt = ~alt; end
      else if (mode == 2) gap = ($urandom_range(0, 99) < 30);
      else gap = 1'b0;
      if (gap) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        if (poke && $urandom_range(0, 3) == 0) begin load_start = 1'b1; load_len = (AW+1)'(1); end
        if ($urandom_range(0, 1) == 1) cpu_addr = $urandom;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = b[i];
        if (bus.in_ready) i++;
      end
      guard++;
      if (guard > 8 * b.size() + 40) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout: %0d of %0d bytes accepted", i, b.size());
        break;
      end
    end
  endtask

  task automatic run_load(input string tag, input int len, input wq_t words, input int mode,
                          input bit bad_cks, input bit poke);
    int          nw, dc0;
    bq_t         b;
    logic [31:0] sum;
    bit          exp_ok;
    wr_t         e;
    nw  = (len > DEPTH) ? DEPTH : len;
    sum = '0;
    for (int i = 0; i < nw; i++) begin
      e.addr = 32'(i * 4);
      e.data = words[i];
      exp_wr.push_back(e);
      sum = sum + words[i];
      for (int k = 0; k < 4; k++) b.push_back(8'(words[i] >> (8 * k)));
    end
    if (CKS) begin
      if (bad_cks) sum = sum + 32'd1;
      for (int k = 0; k < 4; k++) b.push_back(8'(sum >> (8 * k)));
    end
    exp_ok = !(CKS && bad_cks);
    if (exp_ok) exp_done.push_back(mode == 0 ? 5 * nw + 1 + (CKS ? 4 : 0) : -1);
    dc0 = done_cnt;

    @(negedge clk);
    bus.in_valid = 1'b0;
    load_start   = 1'b1;
    load_len     = (AW+1)'(len);
    start_cyc    = cyc;
    @(posedge clk); #2;
    load_start = 1'b0;
    chk({tag, "_busy_t1"}, load_busy, 1);
    chk({tag, "_hold_t1"}, cpu_hold, 1);
    chk({tag, "_ready_t1"}, bus.in_ready, (nw > 0 || CKS));
    chk({tag, "_err_clr"}, load_err, 0);
    chk({tag, "_addr_loader"}, bus.mem_addr, 0);
    chk({tag, "_ww_clr"}, words_written, 0);

    send_bytes(b, mode, poke);
    for (int k = 0; k < 12 && done_cnt == dc0; k++) begin
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      load_start   = 1'b0;
    end
    if (exp_ok) begin
      chk({tag, "_done_seen"}, done_cnt - dc0, 1);
      @(posedge clk); #2;
      chk({tag, "_hold_rel"}, cpu_hold, 0);
      chk({tag, "_busy_end"}, load_busy, 0);
      chk({tag, "_addr_cpu"}, bus.mem_addr, cpu_addr);
      chk({tag, "_words"}, words_written, nw);
    end else begin
      chk({tag, "_no_done"}, done_cnt - dc0, 0);
      chk({tag, "_err_set"}, load_err, 1);
      chk({tag, "_hold_kept"}, cpu_hold, 1);
      chk({tag, "_busy_end"}, load_busy, 0);
      chk({tag, "_words"}, words_written, nw);
    end
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    wq_t w;
    bq_t b6;
    wr_t e;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_we", bus.mem_we, 0);
    chk("rst_wdata", bus.mem_wdata, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_words", words_written, 0);
    chk("rst_addr", bus.mem_addr, 32'h0000_0010);
    @(negedge clk); reset = 1'b0;

    // Bytes offered while idle must be dropped.
    repeat (4) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      cpu_addr     = $urandom;
      @(posedge clk); #2;
      chk("idle_ready", bus.in_ready, 0);
      chk("idle_addr", bus.mem_addr, cpu_addr);
    end

    w = {32'h00A0_0513, 32'h0082_A503};
    run_load("dir2", 2, w, 0, 1'b0, 1'b0);

    w = {32'hDEAD_BEEF};
    run_load("toggle", 1, w, 1, 1'b0, 1'b0);

    w.delete();
    run_load("len0", 0, w, 0, 1'b0, 1'b0);

`ifdef IMEM_LOAD_CHECKSUM_EN
    w = {32'h0000_0001, 32'h0000_0002};
    run_load("cks_ok", 2, w, 0, 1'b0, 1'b0);
    run_load("cks_bad", 2, w, 0, 1'b1, 1'b0);
`endif

    for (int r = 0; r < 10; r++) begin
      int len;
      w.delete();
      len = $urandom_range(0, 9);
      for (int i = 0; i < len; i++) w.push_back($urandom);
      run_load("rnd", len, w, 2, CKS && ($urandom_range(0, 1) == 1), 1'b1);
    end

    w.delete();
    for (int i = 0; i < DEPTH; i++) w.push_back($urandom);
    run_load("sat", 2047, w, 0, 1'b0, 1'b0);

    // Reset after six bytes of a three-word load: only word 0 may reach memory.
    w = {$urandom, $urandom, $urandom};
    e.addr = 32'h0;
    e.data = w[0];
    exp_wr.push_back(e);
    b6.delete();
    for (int i = 0; i < 6; i++) b6.push_back(8'(w[i / 4] >> (8 * (i % 4))));
    @(negedge clk);
    load_start = 1'b1;
    load_len   = (AW+1)'(3);
    @(posedge clk); #2;
    load_start = 1'b0;
    send_bytes(b6, 0, 1'b0);
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_busy", load_busy, 0);
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_words", words_written, 0);
    chk("mid_rst_addr", bus.mem_addr, cpu_addr);
    @(negedge clk); reset = 1'b0;

    w = {$urandom, $urandom};
    run_load("post_rst", 2, w, 0, 1'b0, 1'b0);

    repeat (5) @(posedge clk);
    #2;
    chk("sb_writes_drained", exp_wr.size(), 0);
    chk("sb_done_drained", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
